// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO drain UART transmitter.
package fifo_uart_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    // Clock cycles taken by one complete frame (start, data, optional parity, stop).
    function automatic int unsigned frame_len(input int unsigned bits,
                                              input int unsigned clks_per_bit,
                                              input int unsigned parity_en);
        return (2 + bits + parity_en) * clks_per_bit;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Per-bit cycle counter; tick marks the last cycle of each serial bit.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    // Count up, wrapping after the last cycle of a bit or on a state change.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the SRAM FIFO one word at a time and serialises each word as a UART frame.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned BITS         = 12,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            fifo_ready,
    input  logic [BITS-1:0] fifo_data,
    input  logic            fifo_overflow,
    output logic            fifo_read,
    output logic            tx,
    output logic            busy,
    output logic            frame_done,
    output logic            ovf_sticky,
    input  logic            ovf_clr
);

    localparam int unsigned     IDX_W    = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS - 1);
    localparam logic            PAR_ODD  = (PARITY_ODD != 0);
    localparam logic            PAR_EN   = (PARITY_EN != 0);

    state_e            state_q,      state_d;
    logic [BITS-1:0]   shreg_q,      shreg_d;
    logic              parity_q,     parity_d;
    logic [IDX_W-1:0]  bit_idx_q,    bit_idx_d;
    logic              tx_q,         tx_d;
    logic              fifo_read_q,  fifo_read_d;
    logic              busy_q,       busy_d;
    logic              frame_done_q, frame_done_d;
    logic              ovf_q,        ovf_d;
    logic              tick;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state_d != state_q),
        .tick (tick)
    );

    assign fifo_read  = fifo_read_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign ovf_sticky = ovf_q;

    // Next-state and output decode; line outputs follow the current state one cycle later.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        parity_d     = parity_q;
        bit_idx_d    = bit_idx_q;
        fifo_read_d  = 1'b0;
        frame_done_d = 1'b0;
        tx_d         = 1'b1;
        busy_d       = (state_q != IDLE);
        ovf_d        = fifo_overflow | (ovf_q & ~ovf_clr);

        case (state_q)
            IDLE: begin
                if (enable && fifo_ready) begin
                    fifo_read_d = 1'b1;
                    shreg_d     = fifo_data;
                    parity_d    = (^fifo_data) ^ PAR_ODD;
                    bit_idx_d   = '0;
                    state_d     = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = shreg_q[0];
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
                        state_d   = PAR_EN ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                tx_d = parity_q;
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            parity_q     <= 1'b0;
            bit_idx_q    <= '0;
            tx_q         <= 1'b1;
            fifo_read_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            parity_q     <= parity_d;
            bit_idx_q    <= bit_idx_d;
            tx_q         <= tx_d;
            fifo_read_q  <= fifo_read_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            ovf_q        <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: three instances (even parity, odd parity, no parity).
module tb_fifo_uart_tx;

    localparam int unsigned BITS = 12;
    localparam int unsigned CPB  = 4;
    localparam int          NTR  = 256;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic            fifo_ready;
    logic [BITS-1:0] fifo_data;
    logic            fifo_overflow;
    logic            ovf_clr;

    logic a_read, a_tx, a_busy, a_done, a_ovf;
    logic b_read, b_tx, b_busy, b_done, b_ovf;
    logic c_read, c_tx, c_busy, c_done, c_ovf;

    int errors = 0;
    int checks = 0;

    logic [BITS-1:0] q[$];

    logic tr_read [NTR];
    logic tr_tx   [NTR];
    logic tr_busy [NTR];
    logic tr_done [NTR];
    logic tr_btx  [NTR];
    logic tr_bdone[NTR];
    logic tr_ctx  [NTR];
    logic tr_cdone[NTR];

    always #5 clk = ~clk;

    fifo_uart_tx #(.BITS(BITS), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_ready(fifo_ready),
        .fifo_data(fifo_data), .fifo_overflow(fifo_overflow), .fifo_read(a_read),
        .tx(a_tx), .busy(a_busy), .frame_done(a_done), .ovf_sticky(a_ovf), .ovf_clr(ovf_clr));

    fifo_uart_tx #(.BITS(BITS), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_ready(fifo_ready),
        .fifo_data(fifo_data), .fifo_overflow(fifo_overflow), .fifo_read(b_read),
        .tx(b_tx), .busy(b_busy), .frame_done(b_done), .ovf_sticky(b_ovf), .ovf_clr(ovf_clr));

    fifo_uart_tx #(.BITS(BITS), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut_np (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_ready(fifo_ready),
        .fifo_data(fifo_data), .fifo_overflow(fifo_overflow), .fifo_read(c_read),
        .tx(c_tx), .busy(c_busy), .frame_done(c_done), .ovf_sticky(c_ovf), .ovf_clr(ovf_clr));

    // FIFO model: pops on the main instance's read strobe, presents head word.
    always @(posedge clk) begin
        if (a_read === 1'b1 && q.size() != 0) begin
            void'(q.pop_front());
        end
        fifo_ready <= (q.size() != 0);
        fifo_data  <= (q.size() != 0) ? q[0] : '0;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        enable        = 1'b0;
        fifo_overflow = 1'b0;
        ovf_clr       = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sample n cycles, each just after a rising edge.
    task automatic run_trace(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            tr_read[i]  = a_read;
            tr_tx[i]    = a_tx;
            tr_busy[i]  = a_busy;
            tr_done[i]  = a_done;
            tr_btx[i]   = b_tx;
            tr_bdone[i] = b_done;
            tr_ctx[i]   = c_tx;
            tr_cdone[i] = c_done;
        end
    endtask

    task automatic test_reset();
        logic [14:0] got;
        do_reset();
        got = {a_tx, a_read, a_busy, a_done, a_ovf,
               b_tx, b_read, b_busy, b_done, b_ovf,
               c_tx, c_read, c_busy, c_done, c_ovf};
        checks++;
        if (got !== 15'b10000_10000_10000) begin
            errors++;
            $display("FAIL reset_values: got %b, required %b", got, 15'b10000_10000_10000);
        end
        checks++;
        if (a_tx !== 1'b1 || a_read !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_main: tx=%b read=%b busy=%b, required 1 0 0", a_tx, a_read, a_busy);
        end
    endtask

    task automatic test_frame();
        logic exp_bits [15];
        int n_rd, n_dn, bad, flen;
        exp_bits = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        flen = int'(fifo_uart_pkg::frame_len(BITS, CPB, 1));
        do_reset();
        q.push_back(12'hA5C);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        run_trace(70);
        n_rd = 0;
        n_dn = 0;
        for (int i = 0; i < 70; i++) begin
            n_rd += int'(tr_read[i]);
            n_dn += int'(tr_done[i]);
        end
        checks++;
        if (tr_read[0] !== 1'b1) begin
            errors++;
            $display("FAIL frame_read_first: fifo_read=%b, required 1", tr_read[0]);
        end
        checks++;
        if (n_rd != 1) begin
            errors++;
            $display("FAIL frame_read_count: %0d pulses, required 1", n_rd);
        end
        checks++;
        if (tr_tx[0] !== 1'b1) begin
            errors++;
            $display("FAIL frame_tx_in_read_cycle: tx=%b, required 1", tr_tx[0]);
        end
        for (int b = 0; b < 15; b++) begin
            bad = 0;
            for (int k = 0; k < int'(CPB); k++) begin
                if (tr_tx[1 + int'(CPB) * b + k] !== exp_bits[b]) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL frame_bit%0d: %0d of 4 samples wrong, required tx=%b", b, bad, exp_bits[b]);
            end
        end
        checks++;
        if (tr_done[flen] !== 1'b1 || n_dn != 1) begin
            errors++;
            $display("FAIL frame_done_timing: done@%0d=%b count=%0d, required 1 and 1", flen, tr_done[flen], n_dn);
        end
        checks++;
        if (tr_busy[1] !== 1'b1 || tr_busy[flen] !== 1'b1 || tr_busy[flen + 1] !== 1'b0) begin
            errors++;
            $display("FAIL frame_busy: busy first/last/after=%b%b%b, required 110",
                     tr_busy[1], tr_busy[flen], tr_busy[flen + 1]);
        end
        bad = 0;
        for (int i = flen + 1; i < 70; i++) if (tr_tx[i] !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL frame_idle_after: %0d low samples, required 0", bad);
        end
    endtask

    task automatic test_parity_variants();
        int bad_a, bad_b, bad_c, n_c, flen_np;
        flen_np = int'(fifo_uart_pkg::frame_len(BITS, CPB, 0));
        do_reset();
        q.push_back(12'h001);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        run_trace(70);
        bad_a = 0;
        bad_b = 0;
        bad_c = 0;
        for (int k = 53; k <= 56; k++) begin
            if (tr_tx[k]  !== 1'b1) bad_a++;
            if (tr_btx[k] !== 1'b0) bad_b++;
            if (tr_ctx[k] !== 1'b1) bad_c++;
        end
        checks++;
        if (bad_a != 0) begin
            errors++;
            $display("FAIL even_parity_001: %0d samples wrong, required parity 1", bad_a);
        end
        checks++;
        if (bad_b != 0) begin
            errors++;
            $display("FAIL odd_parity_001: %0d samples wrong, required parity 0", bad_b);
        end
        checks++;
        if (bad_c != 0) begin
            errors++;
            $display("FAIL noparity_stop: %0d samples wrong, required stop 1", bad_c);
        end
        checks++;
        if (tr_btx[5] !== 1'b1 || tr_btx[9] !== 1'b0 || tr_ctx[5] !== 1'b1 || tr_ctx[9] !== 1'b0) begin
            errors++;
            $display("FAIL variant_data_bits: odd b0/b1=%b%b np b0/b1=%b%b, required 10 10",
                     tr_btx[5], tr_btx[9], tr_ctx[5], tr_ctx[9]);
        end
        checks++;
        if (tr_bdone[60] !== 1'b1) begin
            errors++;
            $display("FAIL odd_frame_done: done@60=%b, required 1", tr_bdone[60]);
        end
        n_c = 0;
        for (int i = 0; i < 70; i++) n_c += int'(tr_cdone[i]);
        checks++;
        if (tr_cdone[flen_np] !== 1'b1 || n_c != 1) begin
            errors++;
            $display("FAIL noparity_frame_len: done@%0d=%b count=%0d, required 1 and 1",
                     flen_np, tr_cdone[flen_np], n_c);
        end
    endtask

    task automatic test_back_to_back();
        int n_rd, n_dn, n_blow, bad;
        do_reset();
        q.push_back(12'h123);
        q.push_back(12'hFFF);
        q.push_back(12'h007);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        run_trace(200);
        n_rd = 0;
        n_dn = 0;
        n_blow = 0;
        for (int i = 0; i < 200; i++) begin
            n_rd += int'(tr_read[i]);
            n_dn += int'(tr_done[i]);
        end
        for (int i = 1; i <= 182; i++) if (tr_busy[i] !== 1'b1) n_blow++;
        checks++;
        if (n_rd != 3 || tr_read[0] !== 1'b1 || tr_read[61] !== 1'b1 || tr_read[122] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reads: count=%0d at0/61/122=%b%b%b, required 3 and 111",
                     n_rd, tr_read[0], tr_read[61], tr_read[122]);
        end
        checks++;
        if (n_dn != 3 || tr_done[60] !== 1'b1 || tr_done[121] !== 1'b1 || tr_done[182] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: count=%0d at60/121/182=%b%b%b, required 3 and 111",
                     n_dn, tr_done[60], tr_done[121], tr_done[182]);
        end
        checks++;
        if (tr_tx[61] !== 1'b1 || tr_tx[62] !== 1'b0 || tr_tx[122] !== 1'b1 || tr_tx[123] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: tx 61/62/122/123=%b%b%b%b, required 1010",
                     tr_tx[61], tr_tx[62], tr_tx[122], tr_tx[123]);
        end
        checks++;
        if (tr_tx[114] !== 1'b0 || tr_tx[175] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_parity: frame2=%b frame3=%b, required 0 1", tr_tx[114], tr_tx[175]);
        end
        bad = 0;
        for (int i = 183; i < 200; i++) if (tr_busy[i] !== 1'b0) bad++;
        checks++;
        if (n_blow != 2 || bad != 0) begin
            errors++;
            $display("FAIL b2b_busy: idle gaps=%0d busy after last=%0d, required 2 and 0", n_blow, bad);
        end
    endtask

    task automatic test_enable();
        int n_rd, n_low;
        do_reset();
        q.push_back(12'h3C3);
        run_trace(20);
        n_rd = 0;
        n_low = 0;
        for (int i = 0; i < 20; i++) begin
            n_rd += int'(tr_read[i]);
            if (tr_tx[i] !== 1'b1) n_low++;
        end
        checks++;
        if (n_rd != 0 || n_low != 0) begin
            errors++;
            $display("FAIL enable_off: reads=%0d tx_low=%0d, required 0 and 0", n_rd, n_low);
        end
        enable = 1'b1;
        run_trace(2);
        checks++;
        if (tr_read[0] !== 1'b1 || tr_tx[1] !== 1'b0) begin
            errors++;
            $display("FAIL enable_on: read=%b next tx=%b, required 1 0", tr_read[0], tr_tx[1]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n_rd;
        do_reset();
        q.push_back(12'h001);
        q.push_back(12'h002);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        run_trace(10);
        checks++;
        if (tr_read[0] !== 1'b1 || tr_busy[9] !== 1'b1 || tr_tx[9] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_setup: read=%b busy=%b tx=%b, required 1 1 0", tr_read[0], tr_busy[9], tr_tx[9]);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_read !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_abort: tx=%b busy=%b read=%b, required 1 0 0", a_tx, a_busy, a_read);
        end
        n_rd = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_rd += int'(a_read);
        end
        checks++;
        if (n_rd != 0) begin
            errors++;
            $display("FAIL rst_mid_no_read: %0d reads in reset, required 0", n_rd);
        end
        rst_n = 1'b1;
        run_trace(14);
        checks++;
        if (tr_read[0] !== 1'b1 || tr_tx[6] !== 1'b0 || tr_tx[10] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_next_word: read=%b bit0=%b bit1=%b, required 1 0 1",
                     tr_read[0], tr_tx[6], tr_tx[10]);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        fifo_overflow = 1'b1;
        @(negedge clk);
        fifo_overflow = 1'b0;
        checks++;
        if (a_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: ovf_sticky=%b, required 1", a_ovf);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (a_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold: ovf_sticky=%b, required 1", a_ovf);
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++;
        if (a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf_sticky=%b, required 0", a_ovf);
        end
        ovf_clr       = 1'b1;
        fifo_overflow = 1'b1;
        @(negedge clk);
        ovf_clr       = 1'b0;
        fifo_overflow = 1'b0;
        checks++;
        if (a_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: ovf_sticky=%b, required 1", a_ovf);
        end
        ovf_clr       = 1'b1;
        fifo_overflow = 1'b1;
        @(negedge clk);
        ovf_clr       = 1'b0;
        fifo_overflow = 1'b0;
        checks++;
        if (a_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins_held: ovf_sticky=%b, required 1", a_ovf);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        enable        = 1'b0;
        fifo_overflow = 1'b0;
        ovf_clr       = 1'b0;
        test_reset();
        test_frame();
        test_parity_variants();
        test_back_to_back();
        test_enable();
        test_reset_mid_frame();
        test_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream drain stage for the 12-bit SRAM FIFO.
- Pops words through the FIFO's ready/read handshake and serialises each word onto a single UART-style line: start bit, BITS data bits LSB-first, optional parity bit, one stop bit.
- Mirrors the FIFO overflow flag into a sticky error bit so software sees overflows that the FIFO itself clears on read.

Parameters:
- BITS, 12: data word width; must match the FIFO.
- CLKS_PER_BIT, 16: clock cycles per serial bit; minimum 2.
- PARITY_EN, 1: 1 = parity bit present; 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity; 1 = odd parity. Ignored when PARITY_EN = 0.

Ports:
- clk, input, 1: clock; all logic on posedge.
- rst_n, input, 1: reset, synchronous, active-low.
- enable, input, 1: permits fetching new words; a frame already in progress always completes.
- fifo_ready, input, 1: FIFO has data.
- fifo_data, input, BITS: FIFO data_out; valid whenever fifo_ready = 1.
- fifo_overflow, input, 1: FIFO overflow flag.
- fifo_read, output, 1: pop strobe to the FIFO; single-cycle pulse.
- tx, output, 1: serial line; idles high.
- busy, output, 1: frame in progress.
- frame_done, output, 1: one-cycle pulse at the end of each stop bit.
- ovf_sticky, output, 1: latched overflow indication.
- ovf_clr, input, 1: clears ovf_sticky.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: tx = 1, fifo_read = 0, busy = 0, frame_done = 0, ovf_sticky = 0. State = IDLE; all counters 0.
- All outputs are registered.
- States and transitions:
  - IDLE: when enable && fifo_ready, drive fifo_read = 1 for this cycle only. In the same cycle, capture fifo_data into the shift register and compute parity, then go to START. Otherwise stay in IDLE with tx = 1.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx = shreg[0]; shift right every CLKS_PER_BIT cycles. Bit index counts 0..BITS-1. After bit BITS-1 completes, go to PARITY if PARITY_EN, otherwise STOP.
  - PARITY: tx = (^word) ^ PARITY_ODD for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles. frame_done pulses on the last cycle of STOP; then go to IDLE.
- Timing:
  - Because tx is registered, it goes low on the cycle after fifo_read.
  - Frame length is (2 + BITS + PARITY_EN) * CLKS_PER_BIT cycles; 240 with the defaults.
  - Between frames there is exactly one IDLE cycle with tx = 1.
- busy = 1 in every state except IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1. Width is $clog2(CLKS_PER_BIT), minimum 1. The timer resets to 0 on every state change.
- fifo_read rules:
  - Never asserted outside IDLE.
  - Never asserted when fifo_ready = 0.
  - Never asserted on two consecutive cycles.
- Dropping enable mid-frame has no effect on that frame; IDLE simply holds afterwards.
- A word is consumed at the fifo_read edge. A reset mid-frame abandons that word: tx = 1 on the next edge and there is no retry.
- ovf_sticky:
  - Set on any cycle with fifo_overflow = 1.
  - Cleared by ovf_clr.
  - When both occur in the same cycle, set wins.
- fifo_ready dropping while in IDLE simply prevents a fetch. fifo_ready toggling during a frame is ignored.

Decomposition:
- Package fifo_uart_pkg holds:
  - state encoding localparams: IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4 (3-bit);
  - a frame-length function of (BITS, CLKS_PER_BIT, PARITY_EN), used by the bench.
- Sub-module uart_bit_timer (parameter CLKS_PER_BIT):
  - inputs clk, rst_n, clear;
  - output tick, high on count CLKS_PER_BIT-1.
  - The FSM advances on tick.

Test Plan:
- Defaults, CLKS_PER_BIT = 4, FIFO holds 0xA5C, enable = 1:
  - fifo_read is high for exactly one cycle;
  - tx sequence per 4-cycle bit: 0, then 0,0,1,1,1,0,1,0,0,1,0,1 (LSB-first), then parity 0, then stop 1;
  - frame_done fires 60 cycles after the first tx low.
- PARITY_ODD = 1, word 0x001 -> parity bit 0. Same word with PARITY_EN = 0 -> frame is 56 cycles with CLKS_PER_BIT = 4.
- Three words preloaded, enable held high:
  - three frames go out separated by exactly one tx = 1 IDLE cycle;
  - three fifo_read pulses in total;
  - busy drops only after the third frame_done.
- enable = 0 with fifo_ready = 1 -> no fifo_read and tx stays 1 indefinitely. Raising enable -> fifo_read on the next cycle.
- rst_n low in the middle of DATA, synchronous -> tx = 1 and busy = 0 at the next edge; no further fifo_read until rst_n is high and the FSM is in IDLE.
- fifo_overflow pulsed 1 cycle -> ovf_sticky = 1 and it holds. ovf_clr alone -> 0. ovf_clr and fifo_overflow in the same cycle -> stays 1.
